mem_mode_ctrl: RTL and testbench

- Sequences the CPU's operating mode and arbitrates the single-port program/data RAM between three users: the external program loader (IN), the memory checker (CHECK) and the CPU core (RUN).
- Drives the 2-bit `cpustate` consumed by the control unit. The control unit runs only while `cpustate == 2'b11`, so this block also restarts the core.
- Sits between the front-panel/loader logic, the CPU core's memory strobes and the synchronous RAM.

---
 rtl/mem_mode_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_mode_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mode_ctrl.sv
// Mode sequencer and single-port RAM arbiter for the loader (IN), memory
// checker (CHECK) and CPU core (RUN); drives cpustate to the control unit.
module mem_mode_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_sel,
    input  logic          mode_go,
    output logic [1:0]    cpustate,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_full,
    input  logic          chk_step,
    output logic [AW-1:0] chk_addr,
    output logic [DW-1:0] chk_data,
    output logic          chk_valid,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_read,
    input  logic          cpu_write,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    // Low two bits of the encoding are the visible cpustate; PRE_RUN reads as 00.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_IN      = 3'b001,
        ST_CHECK   = 3'b010,
        ST_RUN     = 3'b011,
        ST_PRE_RUN = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        CK_ISSUE   = 2'b00,
        CK_CAPTURE = 2'b01,
        CK_SHOW    = 2'b10
    } chk_e;

    mode_e         state_q, state_d;
    chk_e          chk_st_q, chk_st_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic          ld_full_q, ld_full_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [DW-1:0] chk_data_q, chk_data_d;
    logic          ld_accept;

    assign ld_accept = (state_q == ST_IN) && ld_valid && !ld_full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            chk_st_q   <= CK_ISSUE;
            ld_ptr_q   <= '0;
            ld_full_q  <= 1'b0;
            chk_addr_q <= '0;
            chk_data_q <= '0;
        end else begin
            state_q    <= state_d;
            chk_st_q   <= chk_st_d;
            ld_ptr_q   <= ld_ptr_d;
            ld_full_q  <= ld_full_d;
            chk_addr_q <= chk_addr_d;
            chk_data_q <= chk_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_go) begin
            case (mode_sel)
                2'b01:   state_d = ST_IN;
                2'b10:   state_d = ST_CHECK;
                2'b11:   state_d = ST_PRE_RUN;
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_PRE_RUN) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        ld_ptr_d   = ld_ptr_q;
        ld_full_d  = ld_full_q;
        chk_st_d   = chk_st_q;
        chk_addr_d = chk_addr_q;
        chk_data_d = chk_data_q;

        if (mode_go && (mode_sel == 2'b01)) begin
            ld_ptr_d  = '0;
            ld_full_d = 1'b0;
        end else if (ld_accept) begin
            ld_ptr_d = ld_ptr_q + AW'(1);
            if (ld_ptr_q == '1) ld_full_d = 1'b1;
        end

        // Any mode change abandons an in-flight checker read.
        if (mode_go) begin
            chk_st_d = CK_ISSUE;
            if (mode_sel == 2'b10) chk_addr_d = '0;
        end else if (state_q == ST_CHECK) begin
            case (chk_st_q)
                CK_ISSUE:   chk_st_d = CK_CAPTURE;
                CK_CAPTURE: begin
                    chk_data_d = mem_rdata;
                    chk_st_d   = CK_SHOW;
                end
                CK_SHOW: begin
                    if (chk_step) begin
                        chk_addr_d = chk_addr_q + AW'(1);
                        chk_st_d   = CK_ISSUE;
                    end
                end
                default:    chk_st_d = CK_ISSUE;
            endcase
        end
    end

    always_comb begin
        ld_ready  = 1'b0;
        chk_valid = 1'b0;
        cpu_rdata = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            ST_IN: begin
                ld_ready = !ld_full_q;
                if (ld_accept) begin
                    mem_we    = 1'b1;
                    mem_addr  = ld_ptr_q;
                    mem_wdata = ld_data;
                end
            end
            ST_CHECK: begin
                if (chk_st_q == CK_ISSUE) begin
                    mem_re   = 1'b1;
                    mem_addr = chk_addr_q;
                end
                chk_valid = (chk_st_q == CK_SHOW);
            end
            ST_RUN: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_write;
                mem_re    = cpu_read && !cpu_write;
                cpu_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign cpustate = state_q[1:0];
    assign ld_full  = ld_full_q;
    assign chk_addr = chk_addr_q;
    assign chk_data = chk_data_q;

endmodule

// File: tb/tb_mem_mode_ctrl.sv
// Randomised bench for mem_mode_ctrl: a behavioural RAM plus a cycle-level
// reference model of modes, loader, checker and CPU paths.
module tb_mem_mode_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_sel;
    logic          mode_go;
    logic [1:0]    cpustate;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_full;
    logic          chk_step;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] chk_data;
    logic          chk_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_mode_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .mode_go(mode_go),
        .cpustate(cpustate), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_full(ld_full), .chk_step(chk_step),
        .chk_addr(chk_addr), .chk_data(chk_data), .chk_valid(chk_valid),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read),
        .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM seen by the DUT.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cur 0..3 = visible mode, 4 = the hidden pre-run cycle.
    int            cur, ptr, cnt, caddr;
    bit            full;
    logic [DW-1:0] cdata, rdata_m;
    logic [DW-1:0] mref [0:255];

    task automatic model_reset();
        cur = 0; ptr = 0; cnt = 0; caddr = 0; full = 0; cdata = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        mode_sel = 2'b00; mode_go = 0; ld_valid = 0; ld_data = '0; chk_step = 0;
        cpu_addr = '0; cpu_wdata = '0; cpu_read = 0; cpu_write = 0;
    endtask

    task automatic sample();
        bit acc;
        @(negedge clk);
        acc = (cur == 1) && ld_valid && !full;
        check("cpustate", 32'(cpustate), (cur == 4) ? 0 : cur);
        check("ld_ready", 32'(ld_ready), 32'((cur == 1) && !full));
        check("ld_full", 32'(ld_full), 32'(full));
        check("chk_addr", 32'(chk_addr), caddr);
        check("chk_data", 32'(chk_data), 32'(cdata));
        check("chk_valid", 32'(chk_valid), 32'((cur == 2) && (cnt == 2)));
        check("mem_we", 32'(mem_we), 32'(acc || ((cur == 3) && cpu_write)));
        check("mem_re", 32'(mem_re),
              32'(((cur == 2) && (cnt == 0)) || ((cur == 3) && cpu_read && !cpu_write)));
        check("cpu_rdata", 32'(cpu_rdata), (cur == 3) ? 32'(rdata_m) : 0);
        if (acc) check("mem_addr", 32'(mem_addr), ptr);
        else if ((cur == 2) && (cnt == 0)) check("mem_addr", 32'(mem_addr), caddr);
        else if (cur == 3) check("mem_addr", 32'(mem_addr), 32'(cpu_addr));
        else if (cur == 0 || cur == 4) check("mem_addr", 32'(mem_addr), 0);
        if (acc) check("mem_wdata", 32'(mem_wdata), 32'(ld_data));
        else if (cur == 3) check("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        else if (cur == 0 || cur == 4) check("mem_wdata", 32'(mem_wdata), 0);
    endtask

    task automatic advance();
        bit acc, rd;
        int raddr;
        acc   = (cur == 1) && ld_valid && !full;
        rd    = ((cur == 2) && (cnt == 0)) || ((cur == 3) && cpu_read && !cpu_write);
        raddr = (cur == 2) ? caddr : int'(cpu_addr);
        @(posedge clk);
        if (rd) rdata_m = mref[raddr];
        if (acc) mref[ptr] = ld_data;
        if ((cur == 3) && cpu_write) mref[cpu_addr] = cpu_wdata;
        if ((cur == 2) && (cnt == 1) && !mode_go) cdata = mref[caddr];
        if (mode_go && (mode_sel == 2'b01)) begin
            ptr = 0; full = 0;
        end else if (acc) begin
            if (ptr == 255) full = 1;
            ptr = (ptr + 1) % 256;
        end
        if (mode_go) begin
            cnt = 0;
            if (mode_sel == 2'b10) caddr = 0;
        end else if (cur == 2) begin
            if (cnt < 2) cnt++;
            else if (chk_step) begin
                caddr = (caddr + 1) % 256;
                cnt = 0;
            end
        end
        if (mode_go) cur = (mode_sel == 2'b11) ? 4 : int'(mode_sel);
        else if (cur == 4) cur = 3;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic go(input logic [1:0] sel);
        mode_sel = sel; mode_go = 1;
        step();
        mode_go = 0;
    endtask

    initial begin
        int guard;
        rst = 0;
        idle_inputs();
        model_reset();
        sample();
        check("rst_cpustate", 32'(cpustate), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        rst = 1;
        step();

        // IN: first four words pinned, then fill to the top.
        go(2'b01);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_data = 8'(8'hA0 + i);
            sample();
            check("in_we", 32'(mem_we), 1);
            check("in_addr", 32'(mem_addr), i);
            advance();
        end
        guard = 0;
        while (!full && guard < 3000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 8'($urandom);
            step();
            guard++;
        end
        if (!full) check("fill_timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_data = 8'($urandom);
            sample();
            check("full_flag", 32'(ld_full), 1);
            check("full_ready", 32'(ld_ready), 0);
            check("full_no_we", 32'(mem_we), 0);
            advance();
        end
        idle_inputs();

        // CHECK: entry latency, one step, then walk to the wrap.
        go(2'b10);
        step(); step();
        sample();
        check("chk0_valid", 32'(chk_valid), 1);
        check("chk0_addr", 32'(chk_addr), 0);
        check("chk0_data", 32'(chk_data), 32'h0A0);
        chk_step = 1;
        advance();
        chk_step = 0;
        step(); step();
        sample();
        check("chk1_valid", 32'(chk_valid), 1);
        check("chk1_addr", 32'(chk_addr), 1);
        check("chk1_data", 32'(chk_data), 32'h0A1);
        advance();
        guard = 0;
        while ((caddr != 255 || cnt != 2) && guard < 5000) begin
            chk_step = (caddr != 255) && ($urandom_range(0, 1) == 1);
            step();
            guard++;
        end
        if (guard >= 5000) check("walk_timeout", 0, 1);
        chk_step = 1;
        step();
        chk_step = 0;
        step(); step();
        sample();
        check("wrap_addr", 32'(chk_addr), 0);
        check("wrap_data", 32'(chk_data), 32'h0A0);
        check("wrap_valid", 32'(chk_valid), 1);
        advance();

        // RUN: entry, write-wins, read-back, restart from RUN.
        mode_sel = 2'b11; mode_go = 1;
        advance();
        mode_go = 0;
        sample();
        check("prerun_state", 32'(cpustate), 0);
        advance();
        cpu_read = 1; cpu_write = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5C;
        sample();
        check("run_state", 32'(cpustate), 3);
        check("run_ww_we", 32'(mem_we), 1);
        check("run_ww_re", 32'(mem_re), 0);
        advance();
        cpu_write = 0; cpu_wdata = '0;
        sample();
        check("run_rd_re", 32'(mem_re), 1);
        advance();
        cpu_read = 0;
        sample();
        check("run_rdata", 32'(cpu_rdata), 32'h05C);
        advance();
        mode_sel = 2'b11; mode_go = 1;
        advance();
        mode_go = 0;
        sample();
        check("restart_pre", 32'(cpustate), 0);
        advance();
        sample();
        check("restart_run", 32'(cpustate), 3);
        advance();
        idle_inputs();

        // Mode switch in the same cycle as an accepted loader word.
        go(2'b01);
        ld_valid = 1; ld_data = 8'h3C;
        step();
        mode_sel = 2'b10; mode_go = 1; ld_data = 8'h77;
        sample();
        check("sw_we", 32'(mem_we), 1);
        check("sw_addr", 32'(mem_addr), 1);
        check("sw_wdata", 32'(mem_wdata), 32'h077);
        advance();
        mode_go = 0;
        sample();
        check("sw_ready", 32'(ld_ready), 0);
        advance();
        idle_inputs();

        // Random traffic across all modes.
        for (int i = 0; i < 3000; i++) begin
            mode_go   = ($urandom_range(0, 15) == 0);
            mode_sel  = 2'($urandom_range(0, 3));
            ld_valid  = 1'($urandom_range(0, 1));
            ld_data   = 8'($urandom);
            chk_step  = !mode_go && ($urandom_range(0, 2) == 0);
            cpu_addr  = 8'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_read  = 1'($urandom_range(0, 1));
            cpu_write = ($urandom_range(0, 3) == 0);
            step();
        end
        idle_inputs();

        // Asynchronous reset in the middle of a RUN write.
        go(2'b11);
        step(); step();
        cpu_write = 1; cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
        sample();
        #2 rst = 0;
        #1;
        check("arst_cpustate", 32'(cpustate), 0);
        check("arst_we", 32'(mem_we), 0);
        check("arst_ready", 32'(ld_ready), 0);
        check("arst_valid", 32'(chk_valid), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 5; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
